// File: rtl/processor_pkg.sv
// Shared types and encodings for the multicycle ARM-subset control path.
// Set COND_EXEC_EN to enable real ARM condition evaluation in cond_unit.
package processor_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StExecI  = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9
  } state_e;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;
  localparam logic [3:0] AluAnd = 4'b0010;
  localparam logic [3:0] AluOrr = 4'b0011;

  localparam logic [1:0] OpDp     = 2'b00;
  localparam logic [1:0] OpMem    = 2'b01;
  localparam logic [1:0] OpBranch = 2'b10;
  localparam logic [1:0] OpNop    = 2'b11;

  localparam logic [3:0] CmdAnd = 4'b0000;
  localparam logic [3:0] CmdSub = 4'b0010;
  localparam logic [3:0] CmdAdd = 4'b0100;
  localparam logic [3:0] CmdCmp = 4'b1010;
  localparam logic [3:0] CmdOrr = 4'b1100;
  localparam logic [3:0] CmdMov = 4'b1101;
  localparam logic [3:0] CmdMvn = 4'b1111;

  localparam logic [1:0] SrcBReg  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResReadData  = 2'b01;
  localparam logic [1:0] ResAluDirect = 2'b10;

  localparam logic [1:0] ImmDp     = 2'b00;
  localparam logic [1:0] ImmMem    = 2'b01;
  localparam logic [1:0] ImmBranch = 2'b10;

  // MOV/MVN bypass the ALU through the move path, so ADD is a don't-care op for them.
  function automatic logic [3:0] cmd_to_alu(logic [3:0] cmd);
    logic [3:0] alu;
    alu = AluAdd;
    unique case (cmd)
      CmdAnd:         alu = AluAnd;
      CmdSub, CmdCmp: alu = AluSub;
      CmdOrr:         alu = AluOrr;
      CmdAdd:         alu = AluAdd;
      default:        alu = AluAdd;
    endcase
    return alu;
  endfunction

  // Logical ops only own N and Z; C and V are left to the previous arithmetic op.
  function automatic logic is_logical(logic [3:0] cmd);
    return (cmd == CmdAnd) || (cmd == CmdOrr) || (cmd == CmdMov) || (cmd == CmdMvn);
  endfunction

endpackage

// File: rtl/cond_unit.sv
// ARM condition-code evaluator over registered NZCV.
// Without COND_EXEC_EN every instruction executes as AL.
module cond_unit (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

`ifdef COND_EXEC_EN
  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    pass = 1'b0;
    unique case (cond)
      4'h0: pass = z;
      4'h1: pass = ~z;
      4'h2: pass = c;
      4'h3: pass = ~c;
      4'h4: pass = n;
      4'h5: pass = ~n;
      4'h6: pass = v;
      4'h7: pass = ~v;
      4'h8: pass = c & ~z;
      4'h9: pass = ~c | z;
      4'ha: pass = (n == v);
      4'hb: pass = (n != v);
      4'hc: pass = ~z & (n == v);
      4'hd: pass = z | (n != v);
      4'he: pass = 1'b1;
      4'hf: pass = 1'b0;
    endcase
  end
`else
  logic unused_cond_inputs;
  assign unused_cond_inputs = ^{cond, flags};
  assign pass = 1'b1;
`endif

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle sequencer: steps the shared datapath and owns the NZCV flags.
// COND_EXEC_EN (in cond_unit) selects real condition evaluation vs. always-execute.
module multicycle_control_unit
  import processor_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [19:0]        instruction,
  input  logic               sh_imm,
  input  logic [1:0]         sh,
  input  logic [3:0]         alu_flags,
  output logic               pc_write,
  output logic               ir_write,
  output logic               mem_write,
  output logic               reg_write,
  output logic               adr_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         result_src,
  output logic [3:0]         alu_control,
  output logic [1:0]         imm_src,
  output logic [1:0]         reg_src,
  output logic               sh_src,
  output logic               mov_src,
  output logic               mvn_src,
  output logic [1:0]         sh_type,
  output logic [3:0]         flags,
  output logic [STATE_W-1:0] state
);

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic       i_bit, s_bit, cond_pass;
  logic [3:0] dp_alu;
  logic       unused_ir_bits;

  assign cond  = instruction[19:16];
  assign op    = instruction[15:14];
  assign funct = instruction[13:8];
  assign i_bit = funct[5];
  assign cmd   = funct[4:1];
  assign s_bit = funct[0];
  assign dp_alu = cmd_to_alu(cmd);
  assign unused_ir_bits = ^instruction[7:0];

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;

  cond_unit u_cond_unit (
    .cond  (cond),
    .flags (flags_q),
    .pass  (cond_pass)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        unique case (op)
          OpDp:     state_d = i_bit ? StExecI : StExecR;
          OpMem:    state_d = StMemAdr;
          OpBranch: state_d = StBranch;
          OpNop:    state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = funct[0] ? StMemRd : StMemWr;
      StMemRd:  state_d = StMemWb;
      StExecR,
      StExecI:  state_d = StAluWb;
      default:  state_d = StFetch;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if (state_q == StAluWb && s_bit && cond_pass) begin
      if (is_logical(cmd)) begin
        flags_d[3:2] = alu_flags[3:2];
      end else begin
        flags_d = alu_flags;
      end
    end
  end

  always_comb begin
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SrcBReg;
    result_src  = ResAluOut;
    alu_control = AluAdd;
    case (state_q)
      StFetch: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = SrcBFour;
        result_src = ResAluDirect;
      end
      StDecode: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBFour;
      end
      StMemAdr: alu_src_b = SrcBImm;
      StMemRd:  adr_src = 1'b1;
      StMemWb: begin
        result_src = ResReadData;
        reg_write  = cond_pass;
      end
      StMemWr: begin
        adr_src   = 1'b1;
        mem_write = cond_pass;
      end
      StExecR:  alu_control = dp_alu;
      StExecI: begin
        alu_src_b   = SrcBImm;
        alu_control = dp_alu;
      end
      // Keep the ALU on the same operation so alu_flags are valid for capture.
      StAluWb: begin
        alu_src_b   = i_bit ? SrcBImm : SrcBReg;
        alu_control = dp_alu;
        reg_write   = cond_pass && (cmd != CmdCmp);
      end
      // Target is R15 (PC+8 via reg_src) plus the branch offset.
      StBranch: begin
        pc_write   = cond_pass;
        alu_src_b  = SrcBImm;
        result_src = ResAluDirect;
      end
      default: ;
    endcase
  end

  always_comb begin
    imm_src = ImmDp;
    unique case (op)
      OpMem:    imm_src = ImmMem;
      OpBranch: imm_src = ImmBranch;
      default:  imm_src = ImmDp;
    endcase
  end

  assign reg_src = {(op == OpMem) && !funct[0], op == OpBranch};
  assign mov_src = (op == OpDp) && (cmd == CmdMov);
  assign mvn_src = (op == OpDp) && (cmd == CmdMvn);
  assign sh_src  = (mov_src || mvn_src) && !i_bit && sh_imm;
  assign sh_type = sh;
  assign flags   = flags_q;
  assign state   = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed + random checks of the multicycle sequencer against an instruction-level model.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [19:0] instruction = '0;
  logic        sh_imm = 1'b0;
  logic [1:0]  sh = '0;
  logic [3:0]  alu_flags = '0;
  logic        pc_write, ir_write, mem_write, reg_write, adr_src, alu_src_a;
  logic [1:0]  alu_src_b, result_src, imm_src, reg_src, sh_type;
  logic [3:0]  alu_control, flags;
  logic        sh_src, mov_src, mvn_src;
  logic [3:0]  state;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [3:0]  m_flags = 4'b0000;

  multicycle_control_unit #(.STATE_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .sh_imm      (sh_imm),
    .sh          (sh),
    .alu_flags   (alu_flags),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .adr_src     (adr_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .result_src  (result_src),
    .alu_control (alu_control),
    .imm_src     (imm_src),
    .reg_src     (reg_src),
    .sh_src      (sh_src),
    .mov_src     (mov_src),
    .mvn_src     (mvn_src),
    .sh_type     (sh_type),
    .flags       (flags),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n = f[3];
    bit z = f[2];
    bit cy = f[1];
    bit v = f[0];
    bit tbl[16];
    bit ok;
    tbl = '{z, !z, cy, !cy, n, !n, v, !v, cy && !z, !cy || z, n == v, n != v,
            !z && (n == v), z || (n != v), 1'b1, 1'b0};
    ok = tbl[c];
`ifndef COND_EXEC_EN
    ok = 1'b1;
`endif
    return ok;
  endfunction

  function automatic logic [3:0] exp_alu(input logic [3:0] cmd);
    case (cmd)
      4'b0000: return 4'b0010;
      4'b0010, 4'b1010: return 4'b0001;
      4'b1100: return 4'b0011;
      default: return 4'b0000;
    endcase
  endfunction

  // Enter in FETCH; leave one cycle into the following FETCH.
  task automatic run_instr(input string name, input logic [31:0] ir, input logic shi,
                           input logic [1:0] shs, input logic [3:0] af);
    int seq[$];
    logic [1:0] op = ir[27:26];
    logic ib = ir[25];
    logic [3:0] cmd = ir[24:21];
    logic sb = ir[20];
    bit ok = cond_ok(ir[31:28], m_flags);
    bit logical = (cmd == 4'b0000) || (cmd == 4'b1100) || (cmd == 4'b1101) || (cmd == 4'b1111);
    bit is_mov;
    int st;
    string t;
    seq.push_back(0);
    seq.push_back(1);
    case (op)
      2'b00: begin seq.push_back(ib ? 7 : 6); seq.push_back(8); end
      2'b01: begin
        seq.push_back(2);
        if (sb) begin seq.push_back(3); seq.push_back(4); end
        else seq.push_back(5);
      end
      2'b10: seq.push_back(9);
      default: ;
    endcase
    instruction = ir[31:12];
    sh_imm = shi;
    sh = shs;
    alu_flags = af;
    for (int i = 0; i < seq.size(); i++) begin
      #1;
      st = seq[i];
      t = $sformatf("%s c%0d", name, i);
      chk({t, " state"}, 32'(state), 32'(st));
      chk({t, " pc_write"}, 32'(pc_write), 32'((st == 0) || (st == 9 && ok)));
      chk({t, " ir_write"}, 32'(ir_write), 32'(st == 0));
      chk({t, " reg_write"}, 32'(reg_write),
          32'(ok && ((st == 4) || (st == 8 && cmd != 4'b1010))));
      chk({t, " mem_write"}, 32'(mem_write), 32'(ok && st == 5));
      case (st)
        0: begin
          chk({t, " adr_src"}, 32'(adr_src), 32'd0);
          chk({t, " alu_src_a"}, 32'(alu_src_a), 32'd1);
          chk({t, " alu_src_b"}, 32'(alu_src_b), 32'd2);
          chk({t, " result_src"}, 32'(result_src), 32'd2);
          chk({t, " alu_control"}, 32'(alu_control), 32'd0);
        end
        1: begin
          chk({t, " alu_src_a"}, 32'(alu_src_a), 32'd1);
          chk({t, " alu_src_b"}, 32'(alu_src_b), 32'd2);
          chk({t, " alu_control"}, 32'(alu_control), 32'd0);
        end
        2: begin
          chk({t, " alu_src_b"}, 32'(alu_src_b), 32'd1);
          chk({t, " alu_control"}, 32'(alu_control), 32'd0);
        end
        3: chk({t, " adr_src"}, 32'(adr_src), 32'd1);
        4: chk({t, " result_src"}, 32'(result_src), 32'd1);
        6, 7: begin
          chk({t, " alu_control"}, 32'(alu_control), 32'(exp_alu(cmd)));
          chk({t, " alu_src_b"}, 32'(alu_src_b), 32'(st == 7));
        end
        8: begin
          is_mov = (cmd == 4'b1101) || (cmd == 4'b1111);
          chk({t, " mov_src"}, 32'(mov_src), 32'(cmd == 4'b1101));
          chk({t, " mvn_src"}, 32'(mvn_src), 32'(cmd == 4'b1111));
          chk({t, " sh_src"}, 32'(sh_src), 32'(is_mov && !ib && shi));
          chk({t, " sh_type"}, 32'(sh_type), 32'(shs));
          chk({t, " result_src"}, 32'(result_src), 32'd0);
        end
        9: begin
          chk({t, " imm_src"}, 32'(imm_src), 32'd2);
          chk({t, " result_src"}, 32'(result_src), 32'd2);
        end
        default: ;
      endcase
      @(posedge clk);
      #1;
    end
    if (op == 2'b00 && sb && ok) begin
      if (logical) m_flags[3:2] = af[3:2];
      else m_flags = af;
    end
    #1;
    chk({name, " end state"}, 32'(state), 32'd0);
    chk({name, " flags"}, 32'(flags), 32'(m_flags));
  endtask

  initial begin
    logic [31:0] r_ir;
    logic [1:0]  r_sh;
    logic        r_shi;
    logic [3:0]  r_af;

    #12;
    chk("rst state", 32'(state), 32'd0);
    chk("rst flags", 32'(flags), 32'd0);
    chk("rst pc_write", 32'(pc_write), 32'd1);
    chk("rst ir_write", 32'(ir_write), 32'd1);
    chk("rst mem_write", 32'(mem_write), 32'd0);
    chk("rst reg_write", 32'(reg_write), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    run_instr("mov_reg", 32'hE1A03231, 1'b1, 2'b01, 4'b1011);
    run_instr("cmp_z", 32'hE1500000, 1'b0, 2'b00, 4'b0100);
    chk("cmp flags const", 32'(flags), 32'h4);
    run_instr("beq_taken", 32'h0A000002, 1'b0, 2'b00, 4'b0000);
    run_instr("cmp_clr", 32'hE1500000, 1'b0, 2'b00, 4'b0000);
    run_instr("beq_not", 32'h0A000002, 1'b0, 2'b00, 4'b0000);
    run_instr("ldr", 32'hE5912004, 1'b0, 2'b00, 4'b0000);
    run_instr("str", 32'hE5812004, 1'b0, 2'b00, 4'b0000);
    run_instr("cmp_z2", 32'hE1500000, 1'b0, 2'b00, 4'b0100);
    run_instr("addne", 32'h10812003, 1'b0, 2'b00, 4'b0000);
    run_instr("op11_nop", 32'hEC000000, 1'b0, 2'b00, 4'b0000);
    run_instr("cmp_all", 32'hE1500000, 1'b0, 2'b00, 4'b1111);

    // Asynchronous reset in the middle of a load.
    instruction = 20'hE5912;
    repeat (3) @(posedge clk);
    #1;
    chk("midldr state", 32'(state), 32'd3);
    reset = 1'b0;
    #1;
    m_flags = 4'b0000;
    chk("midldr rst state", 32'(state), 32'd0);
    chk("midldr rst flags", 32'(flags), 32'd0);
    chk("midldr rst mem_write", 32'(mem_write), 32'd0);
    chk("midldr rst reg_write", 32'(reg_write), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int k = 0; k < 60; k++) begin
      r_ir = $urandom;
      if (k % 2 == 0) r_ir[27:26] = 2'b00;
      if (k % 3 == 0) r_ir[31:28] = 4'hE;
      r_shi = 1'($urandom_range(0, 1));
      r_sh = 2'($urandom_range(0, 3));
      r_af = 4'($urandom_range(0, 15));
      run_instr($sformatf("rnd%0d_%08h", k, r_ir), r_ir, r_shi, r_sh, r_af);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multicycle sequencer for the ARM-subset processor. It replaces the single-cycle `control_unit` decode with a state machine that steps the shared datapath (one ALU, one unified memory port, register file) through fetch, decode, execute and writeback. It also holds the NZCV flags register and evaluates condition codes. It sits between the instruction register and the datapath mux/enable controls.

## Interface
Parameters:
- `STATE_W`, 4, width of the state register and of the `state` debug output.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low; `reset`=0 clears all state immediately.
- `instruction`  in  20  IR bits [31:12]: cond[31:28], op[27:26], funct[25:20], Rd[15:12].
- `sh_imm`  in  1  IR bit 4; 1 = register-specified shift amount.
- `sh`  in  2  IR bits [6:5], shift type; passed through unchanged as `sh_type`.
- `alu_flags`  in  4  ALU NZCV of the current cycle ([3]=N, [2]=Z, [1]=C, [0]=V).
- `pc_write`, `ir_write`, `mem_write`, `reg_write`  out  1  datapath write enables.
- `adr_src`  out  1  memory address source: 0 = PC, 1 = ALU result register.
- `alu_src_a`  out  1  ALU A operand: 0 = Rn, 1 = PC.
- `alu_src_b`  out  2  ALU B operand: 00 = Rm/shifter, 01 = ExtImm, 10 = constant 4.
- `result_src`  out  2  result source: 00 = ALUOut, 01 = read data, 10 = ALU direct.
- `alu_control`  out  4  ALU operation code (package constants).
- `imm_src`, `reg_src`  out  2  immediate-extend format; register-file read-address select.
- `sh_src`, `mov_src`, `mvn_src`, `sh_type`  out  1/1/1/2  shifter and MOV/MVN path controls.
- `flags`  out  4  registered NZCV.
- `state`  out  STATE_W  current FSM state, for debug.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9.
- Transitions:
  - FETCH→DECODE.
  - DECODE by opcode: op=00,I=0→EXECR; op=00,I=1→EXECI; op=01→MEMADR; op=10→BRANCH; op=11→FETCH (treated as NOP).
  - MEMADR: L=1→MEMRD, L=0→MEMWR.
  - MEMRD→MEMWB→FETCH; MEMWR→FETCH; EXECR/EXECI→ALUWB→FETCH; BRANCH→FETCH.
  - Unused encodings→FETCH.
- FETCH drives: `ir_write`=1, `pc_write`=1, `adr_src`=0, `alu_src_a`=1, `alu_src_b`=10, `result_src`=10, `alu_control`=ADD.
- DECODE drives: `alu_src_a`=1, `alu_src_b`=10, ALU ADD. This computes PC+8 into ALUOut.
- Operation select from cmd = funct[4:1]:
  - AND 0000, SUB 0010, ADD 0100, CMP 1010, ORR 1100, MOV 1101, MVN 1111. Any other cmd decodes as ADD.
  - `mov_src`=1 for MOV; `mvn_src`=1 for MVN.
  - `sh_src`=`sh_imm` for register-form MOV/MVN, else 0.
- Memory and branch states: MEMADR uses ADD with ExtImm. MEMRD sets `adr_src`=1. MEMWB sets `result_src`=01. BRANCH sets `pc_write`, `result_src`=10 and `imm_src`=10.
- Condition pass is evaluated combinationally from cond[31:28] and the registered `flags`, using the 15 ARM conditions. 1111 = never.
- Gating: `reg_write` (MEMWB, ALUWB), `mem_write` (MEMWR) and `pc_write` (BRANCH) are ANDed with condition pass. CMP never asserts `reg_write`.
- Flag update: on leaving ALUWB with S=funct[0]=1 and condition pass, `flags` takes `alu_flags`.
  - ADD, SUB and CMP update all four flags.
  - AND, ORR, MOV and MVN update N and Z only; C and V hold.

## Timing
- Latency from FETCH entry to the next FETCH: BRANCH 3 cycles, data-processing 4, STR 4, LDR 5, op=11 2.
- All outputs are Moore, decoded from `state` plus the stable IR. They are glitch-free with respect to `alu_flags`, except for the ALUWB flag capture.
- Reset values: `state`=FETCH, `flags`=0000. All write enables follow the FETCH decode, so they become active on the first edge after `reset` deasserts.
- `reset` asserted in any state, including mid-LDR: the state goes to FETCH and the flags clear within the same cycle, without waiting for a clock edge.
- A failed condition still walks the full state sequence; only the writes are suppressed.

## Configuration
- `COND_EXEC_EN` defined: condition evaluation is as specified above.
- `COND_EXEC_EN` undefined: condition pass is forced to 1 for every cond field (all instructions execute as AL). The flags register is still maintained.

## Structure
- `processor_pkg` holds: the state enum, `alu_control` codes (ADD 0000, SUB 0001, AND 0010, ORR 0011), op/cmd constants, and `alu_src_b`/`result_src` select codes.
- Sub-module `cond_unit`: inputs cond[3:0] and flags[3:0], output pass. It is purely combinational, and the `COND_EXEC_EN` gating lives here.

## Test plan
- Reset mid-operation: pull `reset`=0 while in MEMRD → `state`=0 and `flags`=0000 without a clock edge; `mem_write`=0 and `reg_write`=0.
- Register-form MOV: IR 0xE1A03231 → states 0,1,6,8,0. In ALUWB: `reg_write`=1, `mov_src`=1, `sh_src`=1, `sh_type`=01.
- CMP: IR 0xE1500000 with `alu_flags`=0100 in ALUWB → `reg_write`=0 throughout; `flags`=0100 after ALUWB.
- Conditional branch: IR 0x0A000002 with `flags`=0100 → BRANCH `pc_write`=1. With `flags`=0000 → `pc_write`=0 in BRANCH. Both take 3 cycles.
- Load then store:
  - LDR IR 0xE5912004 → states 0,1,2,3,4; `adr_src`=1 in MEMRD; `reg_write`=1 and `result_src`=01 in MEMWB.
  - STR IR 0xE5812004 → `mem_write`=1 in MEMWR only.
- Condition disable: IR 0x10812003 (ADDNE) with `flags`=0100 → `reg_write`=0 with `COND_EXEC_EN` defined; `reg_write`=1 without it.
